// File: rtl/cv32e40s_prefetcher_mo_pkg.sv
// Shared types for the multi-outstanding IF-stage prefetcher.
// Provides the address FSM state encoding and the outstanding-count width.
package cv32e40s_prefetcher_mo_pkg;

    typedef enum logic [0:0] {
        IDLE,
        BRANCH_WAIT
    } prefetch_state_e;

    localparam int PF_OUTST_W = 3;

endpackage

// File: rtl/cv32e40s_prefetcher_mo_if.sv
// Request/response bus between the prefetcher and the bus interface adapter.
// master (prefetcher): drives trans_valid_o/trans_addr_o/trans_ptr_access_o,
// receives trans_ready_i and the in-order resp_valid_i strobe.
interface cv32e40s_prefetcher_mo_if;

    logic        trans_valid_o;
    logic        trans_ready_i;
    logic [31:0] trans_addr_o;
    logic        trans_ptr_access_o;
    logic        resp_valid_i;

    modport master (
        output trans_valid_o,
        output trans_addr_o,
        output trans_ptr_access_o,
        input  trans_ready_i,
        input  resp_valid_i
    );

    modport slave (
        input  trans_valid_o,
        input  trans_addr_o,
        input  trans_ptr_access_o,
        output trans_ready_i,
        output resp_valid_i
    );

endinterface

// File: rtl/cv32e40s_prefetch_tag_fifo.sv
// Small circular FIFO holding one tag per in-flight transaction.
// Ports: clk, rst_n (async low), push/wdata, pop/rdata (head), empty, full.
module cv32e40s_prefetch_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (push) begin
                r_mem[r_wp] <= wdata;
                r_wp        <= ptr_inc(r_wp);
            end
            if (pop) r_rp <= ptr_inc(r_rp);
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
        end
    end

    assign rdata = r_mem[r_rp];
    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == CW'(DEPTH));

endmodule

// File: rtl/cv32e40s_prefetcher_mo.sv
// IF-stage successor prefetcher: issues up to MAX_OUTSTANDING bus requests,
// drops responses of pre-branch transactions, tags each with a pointer flag.
// Ports: clk, rst_n, fetch_* (from fetch stage), fifo_free_i, bus (master),
// resp_valid_o/resp_ptr_access_o, outstanding_o.
// Optional: CV32E40S_PREFETCH_PERF_EN adds discard_cnt_o (dropped responses).
module cv32e40s_prefetcher_mo
    import cv32e40s_prefetcher_mo_pkg::*;
#(
    parameter int BUS_BYTES       = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIFO_DEPTH      = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fetch_valid_i,
    output logic                               fetch_ready_o,
    input  logic                               fetch_branch_i,
    input  logic [31:0]                        fetch_branch_addr_i,
    input  logic                               fetch_ptr_access_i,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_free_i,
    cv32e40s_prefetcher_mo_if.master           bus,
    output logic                               resp_valid_o,
    output logic                               resp_ptr_access_o,
    output logic [PF_OUTST_W-1:0]              outstanding_o
`ifdef CV32E40S_PREFETCH_PERF_EN
    ,
    output logic [15:0]                        discard_cnt_o
`endif
);

    prefetch_state_e        r_state;
    prefetch_state_e        w_state_nxt;
    logic [31:0]            r_addr;
    logic                   r_ptr;
    logic [PF_OUTST_W-1:0]  r_outst;
    logic [PF_OUTST_W-1:0]  r_disc;

    logic [31:0]            w_seq;
    logic [31:0]            w_addr;
    logic                   w_ptr;
    logic                   w_space;
    logic                   w_tv;
    logic                   w_acc;
    logic                   w_rv;
    logic                   w_head;
    logic                   w_tag_empty;
    logic                   w_tag_full;

    // The buffer is flushed on a branch, so its free count is irrelevant then.
    // Live (non-discarded) transactions each need a slot downstream.
    assign w_space = fetch_branch_i ||
                     (int'(r_outst - r_disc) < int'(fifo_free_i));
    assign w_tv    = rst_n && fetch_valid_i &&
                     (int'(r_outst) < MAX_OUTSTANDING) && w_space;
    assign w_acc   = w_tv && bus.trans_ready_i;
    assign w_seq   = (r_addr & ~32'(BUS_BYTES - 1)) + 32'(BUS_BYTES);

    always_comb begin
        w_state_nxt = r_state;
        w_addr      = w_seq;
        w_ptr       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (fetch_branch_i) begin
                    w_addr = fetch_branch_addr_i;
                    w_ptr  = fetch_ptr_access_i;
                    if (!w_acc) w_state_nxt = BRANCH_WAIT;
                end
            end
            BRANCH_WAIT: begin
                w_addr = fetch_branch_i ? fetch_branch_addr_i : r_addr;
                w_ptr  = fetch_branch_i ? fetch_ptr_access_i : r_ptr;
                if (w_acc) w_state_nxt = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_ptr   <= 1'b0;
            r_outst <= '0;
            r_disc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (fetch_branch_i || w_acc) begin
                r_addr <= w_addr;
                r_ptr  <= w_ptr;
            end
            r_outst <= r_outst + PF_OUTST_W'(w_acc)
                               - PF_OUTST_W'(bus.resp_valid_i);
            // Everything in flight before the branch (minus a response
            // retiring now) is stale; a same-cycle accept is the new target.
            if (fetch_branch_i)
                r_disc <= r_outst - PF_OUTST_W'(bus.resp_valid_i);
            else if (bus.resp_valid_i && r_disc != '0)
                r_disc <= r_disc - 1'b1;
        end
    end

    cv32e40s_prefetch_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_acc),
        .pop   (bus.resp_valid_i),
        .wdata (w_ptr),
        .rdata (w_head),
        .empty (w_tag_empty),
        .full  (w_tag_full)
    );

    assign w_rv = rst_n && bus.resp_valid_i &&
                  (r_disc == '0) && !fetch_branch_i;

    assign bus.trans_valid_o      = w_tv;
    assign bus.trans_addr_o       = w_addr;
    assign bus.trans_ptr_access_o = w_ptr;
    assign fetch_ready_o          = w_acc;
    assign resp_valid_o           = w_rv;
    assign resp_ptr_access_o      = w_rv && w_head;
    assign outstanding_o          = r_outst;

`ifdef CV32E40S_PREFETCH_PERF_EN
    logic [15:0] r_dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dcnt <= '0;
        else if (bus.resp_valid_i && !w_rv && r_dcnt != 16'hFFFF)
            r_dcnt <= r_dcnt + 1'b1;
    end

    assign discard_cnt_o = r_dcnt;
`endif

    a_resp_legal: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.resp_valid_i && r_outst == '0 && w_tag_empty));
    a_br_align: assert property (@(posedge clk) disable iff (!rst_n)
        !(fetch_branch_i && !fetch_ptr_access_i &&
          (fetch_branch_addr_i & 32'(BUS_BYTES - 1)) != 32'd0));
    a_ptr_align: assert property (@(posedge clk) disable iff (!rst_n)
        !(fetch_branch_i && fetch_ptr_access_i &&
          fetch_branch_addr_i[1:0] != 2'd0));
    a_max_outst: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_tv && int'(r_outst) == MAX_OUTSTANDING));
    a_tag_push: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_acc && w_tag_full && !bus.resp_valid_i));

endmodule

// File: tb/tb_cv32e40s_prefetcher_mo.sv
// Self-checking bench for cv32e40s_prefetcher_mo: directed scenarios plus
// randomized traffic checked against a transaction-queue reference model.
module tb_cv32e40s_prefetcher_mo;

    localparam int BB = 4;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fv = 1'b0;
    logic        fb = 1'b0;
    logic        fp = 1'b0;
    logic [31:0] fba = 32'd0;
    logic [1:0]  ffree = 2'd0;
    logic        fr, rv, rp;
    logic [2:0]  outst;

    logic        fv8 = 1'b0;
    logic        fb8 = 1'b0;
    logic [31:0] fba8 = 32'd0;
    logic [1:0]  ff8 = 2'd3;
    logic        fr8, rv8, rp8;
    logic [2:0]  o8;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CV32E40S_PREFETCH_PERF_EN
    logic [15:0] dc, dc8;
`endif

    cv32e40s_prefetcher_mo_if bus ();
    cv32e40s_prefetcher_mo_if bus8 ();

    cv32e40s_prefetcher_mo #(
        .BUS_BYTES(BB), .MAX_OUTSTANDING(MO), .FIFO_DEPTH(3)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_valid_i       (fv),
        .fetch_ready_o       (fr),
        .fetch_branch_i      (fb),
        .fetch_branch_addr_i (fba),
        .fetch_ptr_access_i  (fp),
        .fifo_free_i         (ffree),
        .bus                 (bus),
        .resp_valid_o        (rv),
        .resp_ptr_access_o   (rp),
`ifdef CV32E40S_PREFETCH_PERF_EN
        .discard_cnt_o       (dc),
`endif
        .outstanding_o       (outst)
    );

    cv32e40s_prefetcher_mo #(
        .BUS_BYTES(8), .MAX_OUTSTANDING(2), .FIFO_DEPTH(3)
    ) dut8 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_valid_i       (fv8),
        .fetch_ready_o       (fr8),
        .fetch_branch_i      (fb8),
        .fetch_branch_addr_i (fba8),
        .fetch_ptr_access_i  (1'b0),
        .fifo_free_i         (ff8),
        .bus                 (bus8),
        .resp_valid_o        (rv8),
        .resp_ptr_access_o   (rp8),
`ifdef CV32E40S_PREFETCH_PERF_EN
        .discard_cnt_o       (dc8),
`endif
        .outstanding_o       (o8)
    );

    always #5 clk = ~clk;

    // Reference model: queue of in-flight transactions, each flagged live
    // or killed by a later branch; plus last issued address / pending target.
    typedef struct {
        logic [31:0] a;
        logic        p;
        logic        live;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_last;
    logic        m_pend;
    logic [31:0] m_paddr;
    logic        m_pptr;
    logic        e_tv, e_acc, e_rv, e_rp, e_p;
    logic [31:0] e_a;

    function automatic void model_clear();
        q.delete();
        m_last  = 32'd0;
        m_pend  = 1'b0;
        m_paddr = 32'd0;
        m_pptr  = 1'b0;
    endfunction

    function automatic void model_eval();
        int live = 0;
        foreach (q[i]) if (q[i].live) live++;
        e_tv  = fv && (q.size() < MO) && (fb || live < int'(ffree));
        e_acc = e_tv && bus.trans_ready_i;
        if (fb) begin
            e_a = fba;
            e_p = fp;
        end else if (m_pend) begin
            e_a = m_paddr;
            e_p = m_pptr;
        end else begin
            e_a = (m_last - (m_last % BB)) + BB;
            e_p = 1'b0;
        end
        e_rv = bus.resp_valid_i && (q.size() > 0) && !fb;
        if (e_rv) e_rv = q[0].live;
        e_rp = e_rv && q[0].p;
    endfunction

    function automatic void model_commit();
        model_eval();
        if (bus.resp_valid_i && q.size() > 0) void'(q.pop_front());
        if (fb) foreach (q[i]) q[i].live = 1'b0;
        if (e_acc) q.push_back('{a: e_a, p: e_p, live: 1'b1});
        if (fb || e_acc) m_last = e_a;
        if (e_acc) m_pend = 1'b0;
        else if (fb) begin
            m_pend  = 1'b1;
            m_paddr = fba;
            m_pptr  = fp;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_commit();
        @(negedge clk);
    endtask

    task automatic apply(input logic v, input logic b, input logic [31:0] a,
                         input logic p, input logic r, input logic [1:0] f,
                         input logic s);
        fv = v; fb = b; fba = a; fp = p;
        bus.trans_ready_i = r; ffree = f; bus.resp_valid_i = s;
        #1;
        model_eval();
    endtask

    task automatic drv(input logic v, input logic b, input logic [31:0] a,
                       input logic p, input logic r, input logic [1:0] f,
                       input logic s);
        tick();
        apply(v, b, a, p, r, f, s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fv = 0; fb = 0; fba = 0; fp = 0; ffree = 0;
        bus.trans_ready_i = 0; bus.resp_valid_i = 0;
        fv8 = 0; fb8 = 0; fba8 = 0;
        bus8.trans_ready_i = 0; bus8.resp_valid_i = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (outst !== 3'd0 || bus.trans_valid_o !== 1'b0 || rv !== 1'b0) begin
            n_bad++;
            $display("FAIL reset got outst=%0d tv=%b rv=%b exp 0 0 0", outst, bus.trans_valid_o, rv);
        end
        n_cmp++;
    endtask

    task automatic test_sequential();
        do_reset();
        drv(1, 1, 32'h100, 0, 1, 3, 0);
        if (bus.trans_valid_o !== 1'b1 || bus.trans_addr_o !== 32'h100 || fr !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_a0 got v=%b a=%h r=%b exp 1 00000100 1", bus.trans_valid_o, bus.trans_addr_o, fr);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 0);
        if (bus.trans_valid_o !== 1'b1 || bus.trans_addr_o !== 32'h104) begin
            n_bad++;
            $display("FAIL seq_a1 got v=%b a=%h exp 1 00000104", bus.trans_valid_o, bus.trans_addr_o);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 0);
        if (bus.trans_valid_o !== 1'b0 || outst !== 3'd2) begin
            n_bad++;
            $display("FAIL seq_full got v=%b outst=%0d exp 0 2", bus.trans_valid_o, outst);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 1);
        if (bus.trans_valid_o !== 1'b0 || rv !== 1'b1) begin
            n_bad++;
            $display("FAIL seq_resp got v=%b rv=%b exp 0 1", bus.trans_valid_o, rv);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 0);
        if (bus.trans_valid_o !== 1'b1 || bus.trans_addr_o !== 32'h108) begin
            n_bad++;
            $display("FAIL seq_a2 got v=%b a=%h exp 1 00000108", bus.trans_valid_o, bus.trans_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_discard();
        do_reset();
        drv(1, 1, 32'h100, 0, 1, 3, 0);
        drv(1, 0, 0, 0, 1, 3, 0);
        drv(1, 1, 32'h200, 0, 1, 3, 0);
        if (bus.trans_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL disc_block got v=%b exp 0", bus.trans_valid_o);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 1);
        if (rv !== 1'b0) begin
            n_bad++;
            $display("FAIL disc_r0 got rv=%b exp 0", rv);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 1);
        if (rv !== 1'b0 || bus.trans_valid_o !== 1'b1 || bus.trans_addr_o !== 32'h200) begin
            n_bad++;
            $display("FAIL disc_r1 got rv=%b v=%b a=%h exp 0 1 00000200", rv, bus.trans_valid_o, bus.trans_addr_o);
        end
        n_cmp++;
        drv(0, 0, 0, 0, 1, 3, 1);
        if (rv !== 1'b1) begin
            n_bad++;
            $display("FAIL disc_live got rv=%b exp 1", rv);
        end
        n_cmp++;
    endtask

    task automatic test_branch_wait();
        do_reset();
        drv(1, 1, 32'h300, 0, 0, 3, 0);
        if (bus.trans_addr_o !== 32'h300 || fr !== 1'b0) begin
            n_bad++;
            $display("FAIL bw_c0 got a=%h r=%b exp 00000300 0", bus.trans_addr_o, fr);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 0, 3, 0);
        if (bus.trans_addr_o !== 32'h300 || bus.trans_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bw_hold got a=%h v=%b exp 00000300 1", bus.trans_addr_o, bus.trans_valid_o);
        end
        n_cmp++;
        drv(1, 1, 32'h400, 0, 0, 3, 0);
        drv(1, 0, 0, 0, 1, 3, 0);
        if (bus.trans_addr_o !== 32'h400 || fr !== 1'b1) begin
            n_bad++;
            $display("FAIL bw_new got a=%h r=%b exp 00000400 1", bus.trans_addr_o, fr);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 0);
        if (bus.trans_addr_o !== 32'h404) begin
            n_bad++;
            $display("FAIL bw_next got a=%h exp 00000404", bus.trans_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_ptr();
        do_reset();
        drv(1, 1, 32'h80, 1, 1, 3, 0);
        if (bus.trans_ptr_access_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ptr_req got %b exp 1", bus.trans_ptr_access_o);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 3, 0);
        if (bus.trans_addr_o !== 32'h84 || bus.trans_ptr_access_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ptr_seq got a=%h p=%b exp 00000084 0", bus.trans_addr_o, bus.trans_ptr_access_o);
        end
        n_cmp++;
        drv(0, 0, 0, 0, 1, 3, 1);
        if (rv !== 1'b1 || rp !== 1'b1) begin
            n_bad++;
            $display("FAIL ptr_r0 got rv=%b rp=%b exp 1 1", rv, rp);
        end
        n_cmp++;
        drv(0, 0, 0, 0, 1, 3, 1);
        if (rv !== 1'b1 || rp !== 1'b0) begin
            n_bad++;
            $display("FAIL ptr_r1 got rv=%b rp=%b exp 1 0", rv, rp);
        end
        n_cmp++;
    endtask

    task automatic test_fifo_free();
        do_reset();
        drv(1, 1, 32'h500, 0, 1, 3, 0);
        drv(1, 0, 0, 0, 1, 1, 0);
        if (bus.trans_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL free1 got v=%b exp 0", bus.trans_valid_o);
        end
        n_cmp++;
        drv(1, 0, 0, 0, 1, 2, 0);
        if (bus.trans_valid_o !== 1'b1 || bus.trans_addr_o !== 32'h504) begin
            n_bad++;
            $display("FAIL free2 got v=%b a=%h exp 1 00000504", bus.trans_valid_o, bus.trans_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drv(1, 1, 32'h600, 0, 1, 3, 0);
        drv(1, 0, 0, 0, 1, 3, 0);
        drv(1, 0, 0, 0, 1, 3, 1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        if (outst !== 3'd0 || bus.trans_valid_o !== 1'b0 || rv !== 1'b0 || fr !== 1'b0) begin
            n_bad++;
            $display("FAIL arst got outst=%0d v=%b rv=%b r=%b exp 0 0 0 0", outst, bus.trans_valid_o, rv, fr);
        end
        n_cmp++;
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1, 1, 32'h700, 0, 1, 3, 0);
        drv(0, 0, 0, 0, 1, 3, 1);
        if (rv !== 1'b1 || outst !== 3'd1) begin
            n_bad++;
            $display("FAIL arst_after got rv=%b outst=%0d exp 1 1", rv, outst);
        end
        n_cmp++;
    endtask

    task automatic test_wrap8();
        do_reset();
        @(negedge clk);
        fv8 = 1; fb8 = 1; fba8 = 32'hFFFF_FFF8; bus8.trans_ready_i = 1;
        #1;
        if (bus8.trans_valid_o !== 1'b1 || bus8.trans_addr_o !== 32'hFFFF_FFF8) begin
            n_bad++;
            $display("FAIL w8_br got v=%b a=%h exp 1 fffffff8", bus8.trans_valid_o, bus8.trans_addr_o);
        end
        n_cmp++;
        @(negedge clk);
        fb8 = 0;
        #1;
        if (bus8.trans_addr_o !== 32'h0 || fr8 !== 1'b1) begin
            n_bad++;
            $display("FAIL w8_wrap got a=%h r=%b exp 00000000 1", bus8.trans_addr_o, fr8);
        end
        n_cmp++;
        @(negedge clk);
        fv8 = 0; bus8.resp_valid_i = 1;
        #1;
        if (rv8 !== 1'b1 || o8 !== 3'd2 || rp8 !== 1'b0) begin
            n_bad++;
            $display("FAIL w8_resp got rv=%b o=%0d rp=%b exp 1 2 0", rv8, o8, rp8);
        end
        n_cmp++;
        @(negedge clk);
        fv8 = 1; bus8.resp_valid_i = 0;
        #1;
        if (bus8.trans_addr_o !== 32'h8) begin
            n_bad++;
            $display("FAIL w8_inc got a=%h exp 00000008", bus8.trans_addr_o);
        end
        n_cmp++;
        @(negedge clk);
        fv8 = 0;
    endtask

    task automatic test_random();
        logic        b, p, s;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tick();
            b = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 3) == 0);
            a = $urandom() & 32'hFFFF_FFFC;
            s = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            apply($urandom_range(0, 3) != 0, b, a, p,
                  $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), s);
            if (bus.trans_valid_o !== e_tv) begin
                n_bad++;
                $display("FAIL rnd_tv cyc %0d got %b exp %b", i, bus.trans_valid_o, e_tv);
            end
            n_cmp++;
            if (fr !== e_acc) begin
                n_bad++;
                $display("FAIL rnd_ready cyc %0d got %b exp %b", i, fr, e_acc);
            end
            n_cmp++;
            if (e_tv) begin
                if (bus.trans_addr_o !== e_a || bus.trans_ptr_access_o !== e_p) begin
                    n_bad++;
                    $display("FAIL rnd_addr cyc %0d got %h/%b exp %h/%b", i, bus.trans_addr_o, bus.trans_ptr_access_o, e_a, e_p);
                end
                n_cmp++;
            end
            if (rv !== e_rv || rp !== e_rp) begin
                n_bad++;
                $display("FAIL rnd_resp cyc %0d got %b/%b exp %b/%b", i, rv, rp, e_rv, e_rp);
            end
            n_cmp++;
            if (outst !== 3'(q.size())) begin
                n_bad++;
                $display("FAIL rnd_outst cyc %0d got %0d exp %0d", i, outst, q.size());
            end
            n_cmp++;
        end
    endtask

    initial begin
        bus.trans_ready_i  = 1'b0;
        bus.resp_valid_i   = 1'b0;
        bus8.trans_ready_i = 1'b0;
        bus8.resp_valid_i  = 1'b0;
        model_clear();
        test_reset();
        test_sequential();
        test_discard();
        test_branch_wait();
        test_ptr();
        test_fifo_free();
        test_async_reset();
        test_wrap8();
        test_random();
        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cv32e40s_prefetcher_mo.md
Name: cv32e40s_prefetcher_mo

Overview:
- Parametrised successor prefetch controller for the IF stage; supports multiple outstanding transactions and configurable bus width.
- Receives control-flow information (fetch_valid_i, branch, pointer-access flag) from the fetch/alignment stage.
- Issues address transactions to the bus interface adapter and enforces the outstanding-transaction limit itself; the fetch stage no longer does this.
- Tracks responses, drops those belonging to pre-branch (killed) transactions, and tags each response with its pointer-access flag.

Parameters:
- BUS_BYTES, 4: bytes per transaction; legal 4 or 8; sets the address increment and alignment.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions; legal 1..4.
- FIFO_DEPTH, 3: downstream instruction buffer depth; sets the fifo_free_i width FW = $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_valid_i  in  1  fetch stage wants a transaction
- fetch_ready_o  out  1  transaction accepted this cycle
- fetch_branch_i  in  1  taken branch / control-flow change
- fetch_branch_addr_i  in  32  branch target (valid with fetch_branch_i)
- fetch_ptr_access_i  in  1  branch target is a pointer (data) access
- fifo_free_i  in  FW  free entries in downstream buffer
- trans_valid_o  out  1  transaction request
- trans_ready_i  in  1  adapter accepts request
- trans_addr_o  out  32  transaction address
- trans_ptr_access_o  out  1  request is a pointer access
- resp_valid_i  in  1  bus response arrives (in order)
- resp_valid_o  out  1  response forwarded to buffer
- resp_ptr_access_o  out  1  forwarded response is a pointer access
- outstanding_o  out  3  current outstanding count

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; trans_addr_q = 0; ptr_q = 0; outstanding_q = 0; discard_q = 0; tag FIFO empty.
  - While reset is held, trans_valid_o, fetch_ready_o and resp_valid_o are 0. Reset mid-operation abandons all outstanding state; no responses are forwarded afterwards.
- Accept: acc = trans_valid_o && trans_ready_i. fetch_ready_o = acc. A request is single-cycle combinational; there is no stability requirement on trans_addr_o.
- Issue gating: trans_valid_o = fetch_valid_i && outstanding_q < MAX_OUTSTANDING && space.
  - Normal cycle: space = (outstanding_q − discard_q) < fifo_free_i.
  - Branch cycle: space = 1, because the buffer is flushed in the same cycle and fifo_free_i is ignored.
- Address FSM:
  - IDLE:
    - On branch: trans_addr_o = fetch_branch_addr_i; trans_ptr_access_o = fetch_ptr_access_i.
    - Otherwise: trans_addr_o = {trans_addr_q[31:log2(BUS_BYTES)], 0} + BUS_BYTES (wraps mod 2^32); trans_ptr_access_o = 0.
    - Branch && !acc → BRANCH_WAIT.
  - BRANCH_WAIT:
    - trans_addr_o = fetch_branch_i ? fetch_branch_addr_i : trans_addr_q; ptr flag follows the same selection.
    - acc → IDLE. A new branch while waiting replaces the target.
  - trans_addr_q and ptr_q load trans_addr_o and trans_ptr_access_o when fetch_branch_i || acc.
- Outstanding counter:
  - outstanding_q += acc; outstanding_q −= resp_valid_i.
  - acc and resp_valid_i in the same cycle leave the count unchanged.
  - outstanding_o = outstanding_q, zero-extended.
- Discard:
  - On fetch_branch_i: discard_q <= outstanding_q − resp_valid_i. A transaction accepted in the branch cycle carries the new target and is never discarded.
  - Otherwise: discard_q decrements on resp_valid_i while nonzero.
  - resp_valid_o = resp_valid_i && discard_q == 0 && !fetch_branch_i.
- Tag FIFO (depth MAX_OUTSTANDING, 1 bit wide):
  - Push trans_ptr_access_o on acc; pop on resp_valid_i, discarded or not.
  - resp_ptr_access_o = head entry, gated by resp_valid_o.
  - Push and pop may occur in the same cycle. Push is never attempted when full; the gating guarantees this.
- Protocol assertions:
  - resp_valid_i with outstanding_q == 0 is illegal.
  - fetch_branch_addr_i must be BUS_BYTES-aligned unless fetch_ptr_access_i = 1 (then word-aligned).
  - trans_valid_o is never high with outstanding_q == MAX_OUTSTANDING.

Optional Feature:
- Macro: CV32E40S_PREFETCH_PERF_EN.
- Defined: adds output discard_cnt_o [15:0]. It increments on every dropped response (resp_valid_i && !resp_valid_o), saturates at 0xFFFF, and resets to 0.
- Undefined: the port does not exist, and no counter logic is present.

Decomposition:
- cv32e40s_pkg additions:
  - prefetch_state_e (IDLE, BRANCH_WAIT), reused as-is.
  - PF_OUTST_W = 3 localparam.
- Sub-module cv32e40s_prefetch_tag_fifo: parameters DEPTH and WIDTH; ports push, pop, wdata, rdata, empty, full; same clock and reset.

Test Plan:
- Sequential fetch, MAX_OUTSTANDING=2, BUS_BYTES=4, branch to 0x100, trans_ready_i=1, fifo_free_i=3: accepted addresses 0x100, 0x104; a third request stays low until the first resp_valid_i, then 0x108 issues.
- Branch to 0x200 with 2 outstanding and no response in that cycle: discard_q=2; the next 2 responses give resp_valid_o=0; the 0x200 response gives resp_valid_o=1.
- Branch with trans_ready_i=0 for 3 cycles: trans_addr_o held at 0x300 in BRANCH_WAIT; a second branch to 0x400 in cycle 2 gives 0x400 accepted, then 0x404.
- BUS_BYTES=8, branch to 0xFFFF_FFF8: next address 0x0000_0000 (wrap); increments of 8.
- Pointer branch (fetch_ptr_access_i=1) to 0x80: its response has resp_ptr_access_o=1; the following incremental 0x84 response has 0.
- fifo_free_i=1 with 1 live outstanding: trans_valid_o=0. Async reset asserted mid-burst: all counters 0; later stale resp_valid_i is excluded by the assertion-checked bench.
